serial_tx: RTL and testbench

Parallel-to-serial frame transmitter; the driving end of the single-bit serial line that our D-flip-flop-based capture stages sample. It accepts a `DATA_W`-bit word via a valid/ready handshake and emits one start bit (0), the data LSB first, and one stop bit (1). Each bit is held for `CLKS_PER_BIT` clocks. It sits between a parallel producer and any downstream serial receiver/sampler.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_tx_bit_timer.sv | 36 +++
 rtl/serial_tx.sv | 104 ++++++++++
 tb/tb_serial_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial line states, levels and sizing helper
package serial_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width for values 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - per-bit clock counter with end-of-bit tick
module bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int             W    = cnt_w(CLKS_PER_BIT);
   localparam logic [W-1:0]   LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - start/data(LSB first)/stop frame transmitter
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              out,
   output logic              busy
);

   localparam int            IW       = cnt_w(DATA_W);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              out_q, out_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              accept;
   logic              tick;

   assign accept = valid && (state_q == IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = START;
               shift_d = data;
               idx_d   = '0;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + IW'(1);
               end
            end
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered, so derive it from where the FSM is going
      case (state_d)
         START:   out_d = START_BIT;
         DATA:    out_d = shift_d[0];
         STOP:    out_d = STOP_BIT;
         default: out_d = LINE_IDLE;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = !ready_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         out_q   <= LINE_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign out   = out_q;
   assign ready = ready_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - randomized self-checking bench for serial_tx
module tb_serial_tx;

   localparam int DW_A  = 8;
   localparam int CPB_A = 4;
   localparam int FR_A  = (DW_A + 2) * CPB_A;
   localparam int DW_B  = 4;
   localparam int CPB_B = 1;
   localparam int FR_B  = (DW_B + 2) * CPB_B;

   logic        clk;
   logic        reset;
   logic [7:0]  data_a;
   logic        valid_a, ready_a, out_a, busy_a;
   logic [3:0]  data_b;
   logic        valid_b, ready_b, out_b, busy_b;

   int n_assert;
   int n_fail;

   serial_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .reset(reset), .data(data_a), .valid(valid_a),
      .ready(ready_a), .out(out_a), .busy(busy_a)
   );

   serial_tx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B)) dut_b (
      .clk(clk), .reset(reset), .data(data_b), .valid(valid_b),
      .ready(ready_b), .out(out_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line bit k of a frame: 0 = start, 1..dw = data LSB first, then stop
   function automatic logic line_bit(input logic [7:0] d, input int dw, input int k);
      if (k == 0) return 1'b0;
      if (k <= dw) return d[k-1];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!(ready_a && ready_b) && n < 200) begin
         step();
         n++;
      end
      n_assert++;
      if (!(ready_a && ready_b)) begin
         n_fail++;
         $display("FAIL wait_ready: ready_a=%b ready_b=%b required 1", ready_a, ready_b);
      end
   endtask

   task automatic frame_a(input logic [7:0] d, input string tag);
      logic e;
      wait_ready();
      data_a = d; valid_a = 1'b1;
      step();
      valid_a = 1'b0; data_a = 8'($urandom);
      for (int c = 0; c < FR_A; c++) begin
         e = line_bit(d, DW_A, c / CPB_A);
         n_assert++;
         if ({out_a, ready_a, busy_a} !== {e, 2'b01}) begin
            n_fail++;
            $display("FAIL %s c%0d: out/ready/busy=%b%b%b required %b01", tag, c, out_a, ready_a, busy_a, e);
         end
         step();
      end
      n_assert++;
      if ({out_a, ready_a, busy_a} !== 3'b110) begin
         n_fail++;
         $display("FAIL %s end: out/ready/busy=%b%b%b required 110", tag, out_a, ready_a, busy_a);
      end
   endtask

   task automatic frame_b(input logic [3:0] d, input string tag);
      logic e;
      wait_ready();
      data_b = d; valid_b = 1'b1;
      step();
      valid_b = 1'b0; data_b = 4'($urandom);
      for (int c = 0; c < FR_B; c++) begin
         e = line_bit({4'h0, d}, DW_B, c / CPB_B);
         n_assert++;
         if ({out_b, ready_b, busy_b} !== {e, 2'b01}) begin
            n_fail++;
            $display("FAIL %s c%0d: out/ready/busy=%b%b%b required %b01", tag, c, out_b, ready_b, busy_b, e);
         end
         step();
      end
      n_assert++;
      if ({out_b, ready_b, busy_b} !== 3'b110) begin
         n_fail++;
         $display("FAIL %s end: out/ready/busy=%b%b%b required 110", tag, out_b, ready_b, busy_b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid_a = 1'b1; data_a = 8'hFF;
      valid_b = 1'b1; data_b = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_assert++;
         if ({out_a, ready_a, busy_a, out_b, ready_b, busy_b} !== 6'b110110) begin
            n_fail++;
            $display("FAIL reset_hold %0d: a=%b%b%b b=%b%b%b required 110 110", i,
                     out_a, ready_a, busy_a, out_b, ready_b, busy_b);
         end
      end
      reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      step();
      n_assert++;
      if ({out_a, ready_a, busy_a} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_release: out/ready/busy=%b%b%b required 110", out_a, ready_a, busy_a);
      end
   endtask

   task automatic test_single();
      frame_a(8'hA5, "single_a5");
   endtask

   task automatic test_random();
      for (int i = 0; i < 5; i++) frame_a(8'($urandom), "random_a");
      for (int i = 0; i < 5; i++) frame_b(4'($urandom), "random_b");
   endtask

   task automatic test_back_to_back();
      logic exp_out[$];
      logic exp_rdy[$];
      for (int k = 0; k < FR_A; k++) begin
         exp_out.push_back(line_bit(8'h00, DW_A, k / CPB_A));
         exp_rdy.push_back(1'b0);
      end
      exp_out.push_back(1'b1);
      exp_rdy.push_back(1'b1);
      for (int k = 0; k < FR_A; k++) begin
         exp_out.push_back(line_bit(8'hFF, DW_A, k / CPB_A));
         exp_rdy.push_back(1'b0);
      end
      wait_ready();
      data_a = 8'h00; valid_a = 1'b1;
      step();
      data_a = 8'hFF;
      for (int c = 0; c < exp_out.size(); c++) begin
         if (c == FR_A + 1) valid_a = 1'b0;
         n_assert++;
         if ({out_a, ready_a} !== {exp_out[c], exp_rdy[c]}) begin
            n_fail++;
            $display("FAIL back_to_back c%0d: out/ready=%b%b required %b%b", c, out_a, ready_a, exp_out[c], exp_rdy[c]);
         end
         step();
      end
      n_assert++;
      if ({out_a, ready_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL back_to_back end: out/ready=%b%b required 11", out_a, ready_a);
      end
   endtask

   task automatic test_busy_ignore();
      logic e;
      wait_ready();
      data_a = 8'h81; valid_a = 1'b1;
      step();
      for (int c = 0; c < FR_A; c++) begin
         if (c >= 2) data_a = 8'h3C;
         valid_a = (c < FR_A - 2) ? c[0] : 1'b0;
         e = line_bit(8'h81, DW_A, c / CPB_A);
         n_assert++;
         if ({out_a, ready_a} !== {e, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_ignore c%0d: out/ready=%b%b required %b0", c, out_a, ready_a, e);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if ({out_a, ready_a, busy_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL busy_ignore idle %0d: out/ready/busy=%b%b%b required 110", i, out_a, ready_a, busy_a);
         end
         step();
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] d;
      logic e;
      d = 8'($urandom);
      wait_ready();
      data_a = d; valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      for (int c = 0; c < 18; c++) begin
         e = line_bit(d, DW_A, c / CPB_A);
         n_assert++;
         if (out_a !== e) begin
            n_fail++;
            $display("FAIL mid_reset pre c%0d: out=%b required %b", c, out_a, e);
         end
         if (c == 17) reset = 1'b1;
         else step();
      end
      step();
      reset = 1'b0;
      n_assert++;
      if ({out_a, ready_a, busy_a} !== 3'b110) begin
         n_fail++;
         $display("FAIL mid_reset after: out/ready/busy=%b%b%b required 110", out_a, ready_a, busy_a);
      end
      step();
      n_assert++;
      if ({out_a, ready_a, busy_a} !== 3'b110) begin
         n_fail++;
         $display("FAIL mid_reset idle: out/ready/busy=%b%b%b required 110", out_a, ready_a, busy_a);
      end
      frame_a(8'h5A, "mid_reset_5a");
   endtask

   task automatic test_small();
      frame_b(4'h9, "small_9");
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      valid_a  = 1'b0; data_a = '0;
      valid_b  = 1'b0; data_b = '0;
      step();
      step();
      test_reset();
      test_single();
      test_small();
      test_back_to_back();
      test_busy_ignore();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
